// File: rtl/logic_op_pkg.sv
// Shared opcode constants, sequencer state encoding and index-width helper
// for the shared logic-op arbiter.
package logic_op_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a requester index; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Requester-side bus of the logic-op arbiter: packed per-requester requests
// and operands in, grant/done/result back out.
interface logic_op_arbiter_if
    import logic_op_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned IdxW = idx_width(N);

    logic [N-1:0]       req;
    logic [2*N-1:0]     op;
    logic [WIDTH*N-1:0] a;
    logic [WIDTH*N-1:0] b;
    logic [N-1:0]       gnt;
    logic [N-1:0]       done;
    logic [WIDTH-1:0]   result;
    logic [IdxW-1:0]    result_id;
    logic               busy;

    modport master (
        output req, op, a, b,
        input  gnt, done, result, result_id, busy
    );

    modport slave (
        input  req, op, a, b,
        output gnt, done, result, result_id, busy
    );

endinterface

// File: rtl/logic_unit.sv
// Combinational 2-operand bitwise logic unit: AND, OR, XOR, XNOR.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered logic unit among N requesters.
// IDLE picks and latches a request, EXEC computes, DONE pulses completion.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    logic_op_arbiter_if.slave bus
);

    localparam int unsigned IdxW = idx_width(N);

    state_e           state_q, state_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [N-1:0]     done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IdxW-1:0]  result_id_q, result_id_d;
    logic             busy_q, busy_d;
    logic [IdxW-1:0]  pick;
    logic [WIDTH-1:0] unit_y;

    // First set request searching upward from p, wrapping at N.
    function automatic logic [IdxW-1:0] rr_pick(input logic [N-1:0]    r,
                                                input logic [IdxW-1:0] p);
        logic [IdxW-1:0] sel;
        logic            found;
        int unsigned     j;
        sel   = p;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(p) + k) % N;
            if (!found && r[j]) begin
                found = 1'b1;
                sel   = IdxW'(j);
            end
        end
        return sel;
    endfunction

    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (unit_y)
    );

    assign pick = rr_pick(bus.req, ptr_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_d       = gnt_q;
        done_d      = done_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        busy_d      = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    idx_d   = pick;
                    op_d    = bus.op[2*int'(pick) +: 2];
                    a_d     = bus.a[WIDTH*int'(pick) +: WIDTH];
                    b_d     = bus.b[WIDTH*int'(pick) +: WIDTH];
                    gnt_d   = N'(1) << pick;
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d    = unit_y;
                result_id_d = idx_q;
                done_d      = N'(1) << idx_q;
                gnt_d       = '0;
                ptr_d       = (idx_q == IdxW'(N - 1)) ? '0 : idx_q + 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done_d  = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            result_q    <= '0;
            result_id_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_id = result_id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter (N=3, WIDTH=4) with a
// round-robin and bitwise-op reference model.
module tb_logic_op_arbiter;

    localparam int unsigned N     = 3;
    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   m_ptr;

    logic [N-1:0]     tb_req;
    logic [1:0]       tb_op [N];
    logic [WIDTH-1:0] tb_a  [N];
    logic [WIDTH-1:0] tb_b  [N];

    logic_op_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    logic_op_arbiter #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < int'(N); k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] model_f(input logic [1:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    task automatic drive();
        bus.req = tb_req;
        for (int i = 0; i < int'(N); i++) begin
            bus.op[2*i +: 2]        = tb_op[i];
            bus.a[WIDTH*i +: WIDTH] = tb_a[i];
            bus.b[WIDTH*i +: WIDTH] = tb_b[i];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tb_req = N'($urandom);
            for (int i = 0; i < int'(N); i++) begin
                tb_op[i] = 2'($urandom);
                tb_a[i]  = WIDTH'($urandom);
                tb_b[i]  = WIDTH'($urandom);
            end
            drive();
            cyc();
            checks++;
            if (bus.gnt !== 3'b000 || bus.done !== 3'b000 || bus.result !== 4'b0000 ||
                bus.result_id !== 2'd0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: gnt=%b done=%b result=%b id=%0d busy=%b, want all 0",
                         c, bus.gnt, bus.done, bus.result, bus.result_id, bus.busy);
            end
        end
        rst    = 1'b0;
        tb_req = '0;
        drive();
        m_ptr = 0;
        cyc();
    endtask

    task automatic test_single();
        tb_op[0] = 2'b00;
        tb_a[0]  = 4'b1100;
        tb_b[0]  = 4'b1010;
        tb_req   = 3'b001;
        drive();
        cyc();
        checks++;
        if (bus.gnt !== 3'b001 || bus.busy !== 1'b1 || bus.done !== 3'b000) begin
            errors++;
            $display("FAIL single cycle1: gnt=%b busy=%b done=%b, want 001 1 000",
                     bus.gnt, bus.busy, bus.done);
        end
        cyc();
        checks++;
        if (bus.done !== 3'b001 || bus.result !== 4'b1000 || bus.result_id !== 2'd0 ||
            bus.busy !== 1'b1 || bus.gnt !== 3'b000) begin
            errors++;
            $display("FAIL single cycle2: done=%b result=%b id=%0d busy=%b gnt=%b, want 001 1000 0 1 000",
                     bus.done, bus.result, bus.result_id, bus.busy, bus.gnt);
        end
        tb_req = '0;
        drive();
        cyc();
        checks++;
        if (bus.done !== 3'b000 || bus.busy !== 1'b0 || bus.result !== 4'b1000) begin
            errors++;
            $display("FAIL single hold: done=%b busy=%b result=%b, want 000 0 1000",
                     bus.done, bus.busy, bus.result);
        end
        m_ptr = 1;
    endtask

    task automatic test_opcode_sweep();
        logic [1:0]       ops [3];
        logic [WIDTH-1:0] exp [3];
        ops = '{2'b01, 2'b10, 2'b11};
        exp = '{4'b0111, 4'b0011, 4'b1100};
        for (int k = 0; k < 3; k++) begin
            tb_op[1] = ops[k];
            tb_a[1]  = 4'b0110;
            tb_b[1]  = 4'b0101;
            tb_req   = 3'b010;
            drive();
            cyc();
            checks++;
            if (bus.gnt !== 3'b010) begin
                errors++;
                $display("FAIL sweep op=%b gnt: got %b want 010", ops[k], bus.gnt);
            end
            cyc();
            checks++;
            if (bus.done !== 3'b010 || bus.result !== exp[k] || bus.result_id !== 2'd1) begin
                errors++;
                $display("FAIL sweep op=%b: done=%b result=%b id=%0d, want 010 %b 1",
                         ops[k], bus.done, bus.result, bus.result_id, exp[k]);
            end
            tb_req = '0;
            drive();
            cyc();
        end
        m_ptr = 2;
    endtask

    task automatic test_random();
        int               g;
        logic [WIDTH-1:0] want;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!tb_req[i]) begin
                    tb_op[i]  = 2'($urandom);
                    tb_a[i]   = WIDTH'($urandom);
                    tb_b[i]   = WIDTH'($urandom);
                    tb_req[i] = 1'($urandom);
                end
            end
            if (tb_req == '0) tb_req[$urandom_range(N - 1, 0)] = 1'b1;
            drive();
            g    = model_pick(tb_req, m_ptr);
            want = model_f(tb_op[g], tb_a[g], tb_b[g]);
            cyc();
            checks++;
            if (bus.gnt !== N'(1 << g)) begin
                errors++;
                $display("FAIL random %0d gnt: got %b want %b (req=%b)",
                         it, bus.gnt, N'(1 << g), tb_req);
            end
            cyc();
            checks++;
            if (bus.done !== N'(1 << g) || bus.result !== want || int'(bus.result_id) != g) begin
                errors++;
                $display("FAIL random %0d done: done=%b result=%b id=%0d, want %b %b %0d",
                         it, bus.done, bus.result, bus.result_id, N'(1 << g), want, g);
            end
            tb_req[g] = 1'b0;
            drive();
            cyc();
            m_ptr = (g + 1) % N;
        end
        tb_req = '0;
        drive();
        cyc();
    endtask

    task automatic test_fairness();
        logic [N-1:0] add   [6];
        int           order [6];
        add   = '{3'b111, 3'b000, 3'b000, 3'b101, 3'b000, 3'b101};
        order = '{0, 1, 2, 0, 2, 0};
        rst    = 1'b1;
        tb_req = '0;
        drive();
        cyc();
        rst   = 1'b0;
        m_ptr = 0;
        for (int k = 0; k < 6; k++) begin
            tb_req = tb_req | add[k];
            drive();
            cyc();
            checks++;
            if (bus.gnt !== N'(1 << order[k])) begin
                errors++;
                $display("FAIL fairness step %0d: gnt=%b want %b", k, bus.gnt, N'(1 << order[k]));
            end
            cyc();
            tb_req[order[k]] = 1'b0;
            drive();
            cyc();
        end
        m_ptr = 1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        tb_req = 3'b100;
        drive();
        cyc();
        checks++;
        if (bus.gnt !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid grant: gnt=%b want 100", bus.gnt);
        end
        rst    = 1'b1;
        tb_req = '0;
        drive();
        cyc();
        rst = 1'b0;
        checks++;
        if (bus.gnt !== 3'b000 || bus.done !== 3'b000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid after: gnt=%b done=%b busy=%b, want 000 000 0",
                     bus.gnt, bus.done, bus.busy);
        end
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (bus.done !== 3'b000) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid stray done: got a done pulse, want none");
        end
        // Pointer must be back at 0, so 0 wins over 1.
        tb_req = 3'b011;
        drive();
        cyc();
        checks++;
        if (bus.gnt !== 3'b001) begin
            errors++;
            $display("FAIL reset_mid ptr: gnt=%b want 001", bus.gnt);
        end
        tb_req = '0;
        drive();
        cyc();
        cyc();
        m_ptr = 1;
    endtask

    task automatic test_withdrawn();
        logic [WIDTH-1:0] want;
        int               gap;
        tb_op[0] = 2'($urandom);
        tb_a[0]  = WIDTH'($urandom);
        tb_b[0]  = WIDTH'($urandom);
        want     = model_f(tb_op[0], tb_a[0], tb_b[0]);
        tb_req   = 3'b001;
        drive();
        cyc();
        checks++;
        if (bus.gnt !== 3'b001) begin
            errors++;
            $display("FAIL withdrawn grant: gnt=%b want 001", bus.gnt);
        end
        tb_req   = '0;
        tb_op[0] = ~tb_op[0];
        tb_a[0]  = ~tb_a[0];
        tb_b[0]  = WIDTH'($urandom);
        drive();
        cyc();
        checks++;
        if (bus.done !== 3'b001 || bus.result !== want || bus.result_id !== 2'd0) begin
            errors++;
            $display("FAIL withdrawn done: done=%b result=%b id=%0d, want 001 %b 0",
                     bus.done, bus.result, bus.result_id, want);
        end
        cyc();
        tb_req = 3'b001;
        drive();
        cyc();
        checks++;
        if (bus.gnt !== 3'b001) begin
            errors++;
            $display("FAIL held first grant: gnt=%b want 001", bus.gnt);
        end
        gap = 0;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            if (bus.gnt === 3'b001) begin
                gap = n;
                break;
            end
        end
        checks++;
        if (gap != 3) begin
            errors++;
            $display("FAIL held regrant gap: got %0d cycles want 3 (0 = none within 10)", gap);
        end
        tb_req = '0;
        drive();
        cyc();
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ptr  = 0;
        rst    = 1'b1;
        tb_req = '0;
        for (int i = 0; i < int'(N); i++) begin
            tb_op[i] = '0;
            tb_a[i]  = '0;
            tb_b[i]  = '0;
        end
        drive();
        test_reset();
        test_single();
        test_opcode_sweep();
        test_random();
        test_fairness();
        test_reset_mid();
        test_withdrawn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
